// File: rtl/iic_slave_regs.sv
// iic_slave_regs: I2C register target; decodes addressed write/read transactions
// onto a parallel 8-bit register bank interface with an auto-incrementing pointer.
module iic_slave_regs #(
    parameter logic [6:0] SLAVE_ADDR = 7'b1110110
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SCL,
    input  logic       SDA_in,
    output logic       SDA_oe,
    output logic [7:0] Reg_addr,
    output logic [7:0] Wr_data,
    output logic       Wr_strobe,
    input  logic [7:0] Rd_data,
    output logic       Rd_strobe,
    output logic       Busy
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE
    } state_t;

    state_t     state, state_n;
    logic [2:0] scl_q, sda_q;
    logic [7:0] shift, shift_n, addr_n, wdata_n;
    logic [3:0] cnt, cnt_n;
    logic       rw, rw_n, oe_n, wstb_n, rstb_n, busy_n;
    logic       scl, sda, scl_rise, scl_fall, start, stop, last;
    logic [7:0] byte_in;

    // [0],[1] synchronize; [2] is the previous sample for edge detection
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], SCL};
            sda_q <= {sda_q[1:0], SDA_in};
        end

    assign scl      = scl_q[1];
    assign sda      = sda_q[1];
    assign scl_rise = scl & ~scl_q[2];
    assign scl_fall = ~scl & scl_q[2];
    // SCL must be high in both samples, so a simultaneous SCL/SDA edge is plain data
    assign start    = ~sda & sda_q[2] & scl & scl_q[2];
    assign stop     = sda & ~sda_q[2] & scl & scl_q[2];
    assign last     = cnt == 4'd7;
    assign byte_in  = {shift[6:0], sda};

    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state     <= IDLE;
            shift     <= 8'h00;
            cnt       <= 4'd0;
            rw        <= 1'b0;
            SDA_oe    <= 1'b0;
            Reg_addr  <= 8'h00;
            Wr_data   <= 8'h00;
            Wr_strobe <= 1'b0;
            Rd_strobe <= 1'b0;
            Busy      <= 1'b0;
        end else begin
            state     <= state_n;
            shift     <= shift_n;
            cnt       <= cnt_n;
            rw        <= rw_n;
            SDA_oe    <= oe_n;
            Reg_addr  <= addr_n;
            Wr_data   <= wdata_n;
            Wr_strobe <= wstb_n;
            Rd_strobe <= rstb_n;
            Busy      <= busy_n;
        end

    always_comb begin
        state_n = state;
        shift_n = shift;
        cnt_n   = cnt;
        rw_n    = rw;
        oe_n    = SDA_oe;
        addr_n  = Wr_strobe ? Reg_addr + 8'd1 : Reg_addr;
        wdata_n = Wr_data;
        wstb_n  = 1'b0;
        rstb_n  = 1'b0;
        busy_n  = Busy;
        if (start) begin
            state_n = ADDR;
            cnt_n   = 4'd0;
            oe_n    = 1'b0;
            busy_n  = 1'b1;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            if (scl_rise && (state == ADDR || state == REG || state == WDATA)) begin
                shift_n = byte_in;
                cnt_n   = last ? 4'd0 : cnt + 4'd1;
            end
            case (state)
                ADDR:
                    if (scl_rise && last) begin
                        rw_n    = sda;
                        state_n = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
                    end
                REG:
                    if (scl_rise && last) begin
                        addr_n  = byte_in;
                        state_n = REG_ACK;
                    end
                WDATA:
                    if (scl_rise && last) begin
                        wdata_n = byte_in;
                        wstb_n  = 1'b1;
                        state_n = WDATA_ACK;
                    end
                // first SCL fall drives the ACK, the second ends it
                ADDR_ACK, REG_ACK, WDATA_ACK:
                    if (scl_fall) begin
                        if (!SDA_oe) begin
                            oe_n = 1'b1;
                            if (state == ADDR_ACK && rw) begin
                                shift_n = Rd_data;
                                rstb_n  = 1'b1;
                            end
                        end else begin
                            oe_n    = (state == ADDR_ACK && rw) ? ~shift[7] : 1'b0;
                            cnt_n   = 4'd0;
                            state_n = state == ADDR_ACK ? (rw ? RDATA : REG) : WDATA;
                        end
                    end
                RDATA:
                    if (scl_rise)
                        cnt_n = cnt + 4'd1;
                    else if (scl_fall) begin
                        if (cnt == 4'd8) begin
                            oe_n    = 1'b0;
                            cnt_n   = 4'd0;
                            state_n = RACK;
                        end else begin
                            oe_n    = ~shift[6];
                            shift_n = {shift[6:0], 1'b0};
                        end
                    end
                // cnt==1 marks that the master ACKed and another byte follows
                RACK:
                    if (scl_rise) begin
                        addr_n = Reg_addr + 8'd1;
                        if (sda)
                            state_n = IGNORE;
                        else
                            cnt_n = 4'd1;
                    end else if (scl_fall && cnt == 4'd1) begin
                        shift_n = Rd_data;
                        rstb_n  = 1'b1;
                        oe_n    = ~Rd_data[7];
                        cnt_n   = 4'd0;
                        state_n = RDATA;
                    end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_iic_slave_regs.sv
// tb_iic_slave_regs: bus-master bench with a pointer/scoreboard model of the
// register protocol; directed scenarios followed by randomized transactions.
module tb_iic_slave_regs;
    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       SCL = 1'b1;
    logic       sda_m = 1'b1;
    logic       SDA_in, SDA_oe, Wr_strobe, Rd_strobe, Busy;
    logic [7:0] Reg_addr, Wr_data, Rd_data;

    int          hp = 12;
    int          n_cmp = 0;
    int          n_err = 0;
    int          rd_cnt = 0;
    int          seen = 0;
    logic [7:0]  ptr = 8'h00;
    logic [15:0] obs_wr[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  tx_q[$];

    always #5 Clk = ~Clk;

    // open-drain bus: the line is low if either side pulls it
    assign SDA_in  = sda_m & ~SDA_oe;
    assign Rd_data = Reg_addr ^ 8'hA5;

    iic_slave_regs dut (
        .Clk(Clk), .Reset(Reset), .SCL(SCL), .SDA_in(SDA_in), .SDA_oe(SDA_oe),
        .Reg_addr(Reg_addr), .Wr_data(Wr_data), .Wr_strobe(Wr_strobe),
        .Rd_data(Rd_data), .Rd_strobe(Rd_strobe), .Busy(Busy)
    );

    always @(negedge Clk) begin
        if (Wr_strobe) obs_wr.push_back({Reg_addr, Wr_data});
        if (Rd_strobe) rd_cnt++;
    end

    task automatic w(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_c;
        sda_m = 1'b1; w(hp / 2);
        SCL = 1'b1;   w(hp / 2);
        sda_m = 1'b0; w(hp / 2);
        SCL = 1'b0;   w(hp / 2);
    endtask

    task automatic stop_c;
        w(hp / 2); sda_m = 1'b0;
        w(hp / 2); SCL = 1'b1;
        w(hp);     sda_m = 1'b1;
        w(hp);
    endtask

    task automatic bit_c(input logic b, output logic s);
        w(hp / 2); sda_m = b;
        w(hp / 2); SCL = 1'b1;
        w(hp / 2); s = SDA_in;
        w(hp / 2); SCL = 1'b0;
    endtask

    task automatic wbyte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_c(b[i], s);
        bit_c(1'b1, s);
        ack = ~s;
    endtask

    task automatic rbyte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_c(1'b1, s);
            d[i] = s;
        end
        bit_c(nack, s);
    endtask

    task automatic check_writes;
        chk("wr_count", obs_wr.size(), exp_wr.size());
        for (int i = seen; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk("wr_pair", obs_wr[i], exp_wr[i]);
        seen = exp_wr.size();
    endtask

    // addr/W, reg, then every byte in tx_q, then STOP
    task automatic write_xfer(input logic [6:0] a, input logic [7:0] r);
        logic ack, hit;
        hit = (a == 7'h76);
        start_c;
        wbyte({a, 1'b0}, ack); chk("addr_ack", ack, hit);
        wbyte(r, ack);         chk("reg_ack", ack, hit);
        if (hit) ptr = r;
        foreach (tx_q[i]) begin
            wbyte(tx_q[i], ack); chk("data_ack", ack, hit);
            if (hit) begin
                exp_wr.push_back({ptr, tx_q[i]});
                ptr++;
            end
        end
        chk("busy_on", Busy, 1);
        stop_c; w(2);
        chk("busy_off", Busy, 0);
        check_writes;
        chk("ptr", Reg_addr, ptr);
    endtask

    // addr/W, reg, Sr, addr/R, n bytes (ACK all but the last), STOP
    task automatic read_xfer(input logic [7:0] r, input int n);
        logic ack;
        logic [7:0] d;
        int r0;
        start_c;
        wbyte({7'h76, 1'b0}, ack); chk("rd_addrw_ack", ack, 1);
        wbyte(r, ack);             chk("rd_reg_ack", ack, 1);
        ptr = r;
        r0 = rd_cnt;
        start_c;
        wbyte({7'h76, 1'b1}, ack); chk("rd_addrr_ack", ack, 1);
        for (int i = 0; i < n; i++) begin
            rbyte(i == n - 1, d);
            chk("rd_byte", d, ptr ^ 8'hA5);
            ptr++;
        end
        w(hp / 2);
        chk("rd_release", SDA_oe, 0);
        stop_c; w(2);
        chk("rd_strobes", rd_cnt - r0, n);
        chk("ptr", Reg_addr, ptr);
        chk("busy_off", Busy, 0);
        check_writes;
    endtask

    initial begin
        logic s, ack;
        logic [6:0] a;
        w(3);
        chk("rst_oe", SDA_oe, 0);
        chk("rst_addr", Reg_addr, 0);
        chk("rst_wdata", Wr_data, 0);
        chk("rst_wstb", Wr_strobe, 0);
        chk("rst_rstb", Rd_strobe, 0);
        chk("rst_busy", Busy, 0);
        Reset = 1'b0; w(5);

        tx_q = '{8'hC0};
        write_xfer(7'h76, 8'h49);

        hp = 40;
        tx_q = '{8'h09}; write_xfer(7'h76, 8'h21);
        tx_q = '{8'h08}; write_xfer(7'h76, 8'h33);
        tx_q = '{8'h16}; write_xfer(7'h76, 8'h34);
        tx_q = '{8'h60}; write_xfer(7'h76, 8'h36);
        hp = 12;

        tx_q = '{8'h11, 8'h22, 8'h33};
        write_xfer(7'h76, 8'hFE);

        read_xfer(8'h10, 2);

        tx_q = '{8'h5A};
        write_xfer(7'h50, 8'h07);

        // partial data byte terminated by STOP
        start_c;
        wbyte({7'h76, 1'b0}, ack); chk("part_addr_ack", ack, 1);
        wbyte(8'h40, ack);         chk("part_reg_ack", ack, 1);
        ptr = 8'h40;
        for (int i = 0; i < 5; i++) bit_c(1'b1, s);
        stop_c; w(2);
        check_writes;
        chk("part_ptr", Reg_addr, ptr);

        // reset while the address ACK is being driven
        start_c;
        for (int i = 7; i >= 0; i--) bit_c(i == 0 ? 1'b0 : 1'(7'h76 >> (i - 1)), s);
        sda_m = 1'b1; w(hp / 2);
        chk("ack_driven", SDA_oe, 1);
        Reset = 1'b1; #1;
        chk("rst_release", SDA_oe, 0);
        w(3); Reset = 1'b0;
        SCL = 1'b1; w(hp);
        ptr = 8'h00;
        chk("rst_ptr", Reg_addr, 0);
        tx_q = '{8'h3C, 8'hC3};
        write_xfer(7'h76, 8'h80);

        for (int k = 0; k < 16; k++) begin
            hp = $urandom_range(10, 20);
            if ($urandom_range(0, 3) == 3)
                read_xfer(8'($urandom), $urandom_range(1, 3));
            else begin
                a = 7'h76;
                if ($urandom_range(0, 4) == 0) begin
                    a = 7'($urandom);
                    if (a == 7'h76) a = 7'h50;
                end
                tx_q.delete();
                for (int j = $urandom_range(0, 3); j > 0; j--) tx_q.push_back(8'($urandom));
                write_xfer(a, 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
